// File: rtl/bcd_seq_ctrl_pkg.sv
// Shared types and default parameters for the sequential binary-to-BCD controller.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned IN_W_DEF   = 11;
  localparam int unsigned DIGITS_DEF = 4;

  // Iteration counter must hold the value IN_W itself.
  function automatic int unsigned cnt_w(input int unsigned in_w);
    return $clog2(in_w + 1);
  endfunction

endpackage

// File: rtl/bcd_seq_ctrl_if.sv
// Input/output valid-ready bundle of the BCD controller.
interface bcd_seq_ctrl_if
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, bcd, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, bcd, busy
  );

endinterface

// File: rtl/bcd_seq_ctrl_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit_c
);

  assign o_digit_c = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Sequential double-dabble converter: one add3+shift iteration per clock,
// valid/ready on both sides, zero-bubble back-to-back conversions.
module bcd_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_seq_ctrl_if.slave  bus
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned WORK_W = BCD_W + IN_W;
  localparam int unsigned CNT_W  = cnt_w(IN_W);

  // The BCD field must be able to hold the largest binary input.
  localparam bit CFG_OK = (longint'(10) ** DIGITS) > ((longint'(1) << IN_W) - 1);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("bcd_seq_ctrl: DIGITS too small for IN_W");
    end
  endgenerate

  state_t              r_state;
  logic [WORK_W-1:0]   r_work;
  logic [CNT_W-1:0]    r_cnt;
  logic [BCD_W-1:0]    r_bcd;
  logic                r_out_valid;
  logic                r_busy;

  logic [BCD_W-1:0]    w_adj;
  logic [WORK_W-1:0]   w_next;
  logic [WORK_W-1:0]   w_load;
  logic                w_in_ready;
  logic                w_accept;

  // One correction cell per digit of the BCD half of the work register.
  generate
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
      add3 u_add3 (
        .i_digit   (r_work[IN_W + 4*g +: 4]),
        .o_digit_c (w_adj[4*g +: 4])
      );
    end
  endgenerate

  assign w_next     = {w_adj, r_work[IN_W-1:0]} << 1;
  assign w_load     = {BCD_W'(0), bus.in_data};
  assign w_in_ready = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_bcd       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_work  <= w_load;
            r_cnt   <= CNT_W'(IN_W);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_work <= w_next;
          r_cnt  <= r_cnt - CNT_W'(1);
          // The edge that sees count==1 runs the last iteration and publishes it.
          if (r_cnt == CNT_W'(1)) begin
            r_bcd       <= w_next[WORK_W-1 -: BCD_W];
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (bus.in_valid) begin
              r_work  <= w_load;
              r_cnt   <= CNT_W'(IN_W);
              r_busy  <= 1'b1;
              r_state <= SHIFT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.bcd       = r_bcd;
  assign bus.busy      = r_busy;

endmodule
